// File: rtl/fifo_rd_streamer.sv
// Purpose : pops words from the async FIFO read port and streams them out as valid/ready beats grouped into packets.
// Latency : a word popped at a rclk edge is presented on m_data in the following cycle; full throughput when m_ready=1.
// Backpressure: a two-entry buffer absorbs the pop already in flight; popping stops at two words, nothing is dropped.
// Optional feature: define RD_PARITY_EN to add the m_parity output (even parity of each buffered word).
module fifo_rd_streamer #(
   parameter int datawidth = 8,
   parameter int pkt_len   = 4,
   parameter int cnt_width = 16
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic [datawidth-1:0] rdata,
   input  logic                 rempty,
   output logic                 rinc,
   input  logic                 flush,
   output logic [datawidth-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic [cnt_width-1:0] pkt_cnt
`ifdef RD_PARITY_EN
   ,
   output logic                 m_parity
`endif
);

   // Each buffer entry carries the data word, plus its parity bit when enabled.
`ifdef RD_PARITY_EN
   localparam int EW = datawidth + 1;
`else
   localparam int EW = datawidth;
`endif

   // Beat counter is at least one bit wide so pkt_len=1 still elaborates.
   localparam int            BW        = (pkt_len > 1) ? $clog2(pkt_len) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(pkt_len - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t        state;
   logic [EW-1:0] in_ent;
   logic [EW-1:0] head_ent;
   logic [EW-1:0] tail_ent;
   logic [BW-1:0] beat;
   logic          pop;
   logic          fire;

`ifdef RD_PARITY_EN
   assign in_ent   = {^rdata, rdata};
   assign m_parity = head_ent[datawidth];
`else
   assign in_ent   = rdata;
`endif

   // Pop only while there is room; the reset term keeps rinc low during reset.
   assign pop     = !rempty & (state != TWO) & !flush & rrst_n;
   assign rinc    = pop;
   assign fire    = m_valid & m_ready;
   assign m_data  = head_ent[datawidth-1:0];
   assign m_last  = m_valid & (beat == LAST_BEAT);

   // Buffer occupancy FSM: head entry drives the stream, tail holds the word popped during a stall.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state    <= EMPTY;
         m_valid  <= 1'b0;
         head_ent <= '0;
         tail_ent <= '0;
      end else if (flush) begin
         state   <= EMPTY;
         m_valid <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (pop) begin
                  head_ent <= in_ent;
                  state    <= ONE;
                  m_valid  <= 1'b1;
               end
            end
            ONE: begin
               if (pop && fire) begin
                  head_ent <= in_ent;
               end else if (pop) begin
                  tail_ent <= in_ent;
                  state    <= TWO;
               end else if (fire) begin
                  state    <= EMPTY;
                  m_valid  <= 1'b0;
               end
            end
            TWO: begin
               if (fire) begin
                  head_ent <= tail_ent;
                  state    <= ONE;
               end
            end
            default: begin
               state   <= EMPTY;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

   // Beat position within the packet and completed-packet count; a fire during flush still counts.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         beat    <= '0;
         pkt_cnt <= '0;
      end else begin
         if (fire && m_last) begin
            pkt_cnt <= pkt_cnt + 1'b1;
         end
         if (flush) begin
            beat <= '0;
         end else if (fire) begin
            beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
module tb_fifo_rd_streamer;

   logic        rclk;
   logic        rrst_n;
   logic [7:0]  rdata;
   logic        rempty;
   logic        rinc;
   logic        flush;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic [15:0] pkt_cnt;
`ifdef RD_PARITY_EN
   logic        m_parity;
`endif

   fifo_rd_streamer #(
      .datawidth(8),
      .pkt_len  (4),
      .cnt_width(16)
   ) dut (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .rdata   (rdata),
      .rempty  (rempty),
      .rinc    (rinc),
      .flush   (flush),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_last  (m_last),
      .pkt_cnt (pkt_cnt)
`ifdef RD_PARITY_EN
      ,
      .m_parity(m_parity)
`endif
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   logic [7:0] fq[$];
   int         n_asrt  = 0;
   int         n_fail  = 0;
   int         pop_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fifo_drive();
      rempty = (fq.size() == 0);
      rdata  = (fq.size() == 0) ? 8'h00 : fq[0];
   endtask

   task automatic push(input logic [7:0] w);
      fq.push_back(w);
      fifo_drive();
   endtask

   // One clock: sample rinc before the edge, retire the popped word just after it.
   task automatic tick();
      logic p;
      #1;
      p = rinc;
      @(posedge rclk);
      #1;
      if (p) begin
         if (fq.size() != 0) void'(fq.pop_front());
         pop_cnt++;
      end
      fifo_drive();
      #1;
   endtask

   initial begin
      int         nfire;
      logic       stalled;
      logic [7:0] held_dat;
      logic       held_last;
      logic [7:0] w;

      // Reset with a non-empty FIFO: nothing may be popped or presented.
      rrst_n  = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b0;
      fifo_drive();
      push(8'hAA);
      #1;
      chk("rst_rinc", rinc, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_last", m_last, 0);
      chk("rst_pktcnt", pkt_cnt, 0);
      tick();
      tick();
      chk("rst_nopop", pop_cnt, 0);
      chk("rst_valid_hold", m_valid, 0);
      fq.delete();
      fifo_drive();
      rrst_n = 1'b1;
      tick();

      // Streaming 0x11..0x18 at full rate.
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
      #1;
      chk("s_first_valid", m_valid, 0);
      chk("s_first_rinc", rinc, 1);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("s_valid", m_valid, 1);
         chk("s_data", m_data, 8'h11 + 8'(i));
         chk("s_last", m_last, (i % 4 == 3) ? 1 : 0);
         tick();
      end
      chk("s_done_valid", m_valid, 0);
      chk("s_pktcnt", pkt_cnt, 2);

      // Stall with three words queued: exactly two pops, head held.
      m_ready = 1'b0;
      pop_cnt = 0;
      push(8'h11);
      push(8'h12);
      push(8'h13);
      tick();
      tick();
      tick();
      chk("bp_pops", pop_cnt, 2);
      chk("bp_rinc", rinc, 0);
      chk("bp_valid", m_valid, 1);
      chk("bp_data", m_data, 8'h11);
      chk("bp_fifo_left", fq.size(), 1);
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_drain_valid", m_valid, 1);
         chk("bp_drain_data", m_data, 8'h11 + 8'(i));
         chk("bp_drain_last", m_last, 0);
         tick();
      end
      chk("bp_empty", m_valid, 0);
      push(8'h14);
      tick();
      chk("bp_beat4_data", m_data, 8'h14);
      chk("bp_beat4_last", m_last, 1);
      tick();
      chk("bp_pktcnt", pkt_cnt, 3);

      // Alternating ready over 12 words; held data must stay stable while stalled.
      for (int i = 0; i < 12; i++) push(8'h31 + 8'(i));
      nfire   = 0;
      stalled = 1'b0;
      held_dat  = 8'h00;
      held_last = 1'b0;
      for (int k = 0; k < 60 && nfire < 12; k++) begin
         m_ready = (k % 2 == 0);
         #1;
         if (stalled) begin
            chk("alt_hold_data", m_data, held_dat);
            chk("alt_hold_last", m_last, held_last);
         end
         if (m_valid && m_ready) begin
            chk("alt_data", m_data, 8'h31 + 8'(nfire));
            chk("alt_last", m_last, (nfire % 4 == 3) ? 1 : 0);
            nfire++;
         end
         stalled   = m_valid && !m_ready;
         held_dat  = m_data;
         held_last = m_last;
         tick();
      end
      chk("alt_fires", nfire, 12);
      chk("alt_pktcnt", pkt_cnt, 6);

      // Flush after two beats with two words buffered.
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(8'h41 + 8'(i));
      tick();
      chk("fl_b0", m_data, 8'h41);
      tick();
      chk("fl_b1", m_data, 8'h42);
      tick();
      m_ready = 1'b0;
      tick();
      chk("fl_head", m_data, 8'h43);
      chk("fl_fifo_left", fq.size(), 4);
      flush = 1'b1;
      #1;
      chk("fl_rinc", rinc, 0);
      tick();
      flush = 1'b0;
      chk("fl_valid", m_valid, 0);
      chk("fl_pktcnt_kept", pkt_cnt, 6);
      m_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("fl_post_data", m_data, 8'h45 + 8'(i));
         chk("fl_post_last", m_last, (i == 3) ? 1 : 0);
         tick();
      end
      chk("fl_pktcnt", pkt_cnt, 7);

`ifdef RD_PARITY_EN
      // Parity travels with each buffered word.
      m_ready = 1'b0;
      push(8'h07);
      push(8'h03);
      tick();
      chk("par_07_data", m_data, 8'h07);
      chk("par_07", m_parity, 1);
      tick();
      chk("par_hold", m_parity, 1);
      m_ready = 1'b1;
      tick();
      chk("par_03_data", m_data, 8'h03);
      chk("par_03", m_parity, 0);
      tick();
`endif

      // Reset mid-packet: outputs clear before the next edge, packet restarts at beat 0.
      m_ready = 1'b1;
      push(8'h51);
      push(8'h52);
      push(8'h53);
      tick();
      tick();
      m_ready = 1'b0;
      chk("mr_pre_data", m_data, 8'h52);
      rrst_n = 1'b0;
      #1;
      chk("mr_valid", m_valid, 0);
      chk("mr_data", m_data, 0);
      chk("mr_last", m_last, 0);
      chk("mr_rinc", rinc, 0);
      chk("mr_pktcnt", pkt_cnt, 0);
      tick();
      rrst_n = 1'b1;
      push(8'h54);
      push(8'h55);
      push(8'h56);
      m_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         w = 8'h53 + 8'(i);
         chk("mr_post_data", m_data, w);
         chk("mr_post_last", m_last, (i == 3) ? 1 : 0);
         tick();
      end
      chk("mr_pktcnt_after", pkt_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
